id_ex_pipeline: RTL and testbench

ID/EX pipeline register with built-in load-use hazard detection. It sits between decode and execute. It captures decoded operands, register indices and control bits, and it presents ID_EX_RS1/ID_EX_RS2 to the forwarding unit. On a load-use hazard it inserts a bubble and freezes PC and IF/ID. On a taken branch it flushes. On a downstream memory stall it holds its contents, and any flush requested during the hold is remembered and applied when the hold releases.

---
 rtl/id_ex_pipeline.sv | 133 +++++++++++++
 tb/tb_id_ex_pipeline.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, memory-stall hold
// and deferred flush. Optional performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_pipeline #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IF_ID_valid,
  input  logic [4:0]        IF_ID_RS1,
  input  logic [4:0]        IF_ID_RS2,
  input  logic [4:0]        IF_ID_rd,
  input  logic [DATA_W-1:0] IF_ID_pc,
  input  logic [DATA_W-1:0] IF_ID_imm,
  input  logic [DATA_W-1:0] IF_ID_rd1,
  input  logic [DATA_W-1:0] IF_ID_rd2,
  input  logic [8:0]        IF_ID_ctrl,
  input  logic              Branch_Taken,
  input  logic              Mem_Stall,
  output logic              ID_EX_valid,
  output logic [4:0]        ID_EX_RS1,
  output logic [4:0]        ID_EX_RS2,
  output logic [4:0]        ID_EX_rd,
  output logic [DATA_W-1:0] ID_EX_pc,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic [DATA_W-1:0] ID_EX_rd1,
  output logic [DATA_W-1:0] ID_EX_rd2,
  output logic [8:0]        ID_EX_ctrl,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic [31:0]       Stall_Count,
  output logic [31:0]       Flush_Count
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_valid;
  logic [4:0]          r_rs1, r_rs2, r_rd;
  logic [DATA_W-1:0]   r_pc, r_imm, r_rd1, r_rd2;
  logic [8:0]          r_ctrl;

  logic w_hz, w_flush, w_take_flush, w_take_hz, w_load, w_enable;

  // ctrl bit 7 is MemRead
  always_comb begin
    w_hz = r_valid && r_ctrl[7] && (r_rd != 5'd0) && IF_ID_valid &&
           ((r_rd == IF_ID_RS1) || (r_rd == IF_ID_RS2));
    w_flush      = Branch_Taken || (r_state == PEND);
    w_take_flush = !Mem_Stall && w_flush;
    w_take_hz    = !Mem_Stall && !w_flush && w_hz;
    w_load       = !Mem_Stall && !w_flush && !w_hz;
    w_enable     = !reset && !(Mem_Stall || (w_hz && !w_flush));
    w_state_nxt  = r_state;
    if (Mem_Stall) begin
      if (Branch_Taken) w_state_nxt = PEND;
    end else if (w_flush) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // An invalid decode slot is loaded exactly like a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_ctrl  <= '0;
    end else if (w_take_flush || w_take_hz || (w_load && !IF_ID_valid)) begin
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_ctrl  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_rs1   <= IF_ID_RS1;
      r_rs2   <= IF_ID_RS2;
      r_rd    <= IF_ID_rd;
      r_pc    <= IF_ID_pc;
      r_imm   <= IF_ID_imm;
      r_rd1   <= IF_ID_rd1;
      r_rd2   <= IF_ID_rd2;
      r_ctrl  <= IF_ID_ctrl;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_take_hz && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_take_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_Count = r_stall_cnt;
  assign Flush_Count = r_flush_cnt;
`else
  assign Stall_Count = '0;
  assign Flush_Count = '0;
`endif

  assign ID_EX_valid = r_valid;
  assign ID_EX_RS1   = r_rs1;
  assign ID_EX_RS2   = r_rs2;
  assign ID_EX_rd    = r_rd;
  assign ID_EX_pc    = r_pc;
  assign ID_EX_imm   = r_imm;
  assign ID_EX_rd1   = r_rd1;
  assign ID_EX_rd2   = r_rd2;
  assign ID_EX_ctrl  = r_ctrl;
  assign PC_Write    = w_enable;
  assign IF_ID_Write = w_enable;

endmodule

// File: tb/tb_id_ex_pipeline.sv
// Directed bench for id_ex_pipeline: reset, load-use bubble, x0 consumer, stall with
// deferred flush, flush-over-hazard priority, invalid slot and counter behaviour.
module tb_id_ex_pipeline;

`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_RS1, IF_ID_RS2, IF_ID_rd;
  logic [31:0] IF_ID_pc, IF_ID_imm, IF_ID_rd1, IF_ID_rd2;
  logic [8:0]  IF_ID_ctrl;
  logic        Branch_Taken, Mem_Stall;
  logic        ID_EX_valid;
  logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_rd;
  logic [31:0] ID_EX_pc, ID_EX_imm, ID_EX_rd1, ID_EX_rd2;
  logic [8:0]  ID_EX_ctrl;
  logic        PC_Write, IF_ID_Write;
  logic [31:0] Stall_Count, Flush_Count;

  int n_checks = 0;
  int n_err    = 0;

  id_ex_pipeline #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .IF_ID_valid(IF_ID_valid),
    .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .IF_ID_rd(IF_ID_rd),
    .IF_ID_pc(IF_ID_pc), .IF_ID_imm(IF_ID_imm), .IF_ID_rd1(IF_ID_rd1), .IF_ID_rd2(IF_ID_rd2),
    .IF_ID_ctrl(IF_ID_ctrl), .Branch_Taken(Branch_Taken), .Mem_Stall(Mem_Stall),
    .ID_EX_valid(ID_EX_valid), .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm), .ID_EX_rd1(ID_EX_rd1), .ID_EX_rd2(ID_EX_rd2),
    .ID_EX_ctrl(ID_EX_ctrl), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] pc, input logic [8:0] ctrl);
    IF_ID_valid = v;
    IF_ID_RS1   = rs1;
    IF_ID_RS2   = rs2;
    IF_ID_rd    = rd;
    IF_ID_pc    = pc;
    IF_ID_imm   = pc + 32'h1000;
    IF_ID_rd1   = pc + 32'h2000;
    IF_ID_rd2   = pc + 32'h3000;
    IF_ID_ctrl  = ctrl;
  endtask

  initial begin
    reset = 1'b1;
    Branch_Taken = 1'b0;
    Mem_Stall = 1'b0;
    drive(1'b1, 5'd5, 5'd6, 5'd7, 32'h100, 9'h100);
    #1;
    chk("reset_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("reset_pcw", {31'd0, PC_Write}, 32'd0);
    chk("reset_stallcnt", Stall_Count, 32'd0);
    step();
    chk("reset_held_rs1", {27'd0, ID_EX_RS1}, 32'd0);
    reset = 1'b0;
    #1;
    chk("pcw_after_reset", {31'd0, PC_Write}, 32'd1);

    // basic load
    step();
    chk("load_rs1", {27'd0, ID_EX_RS1}, 32'd5);
    chk("load_valid", {31'd0, ID_EX_valid}, 32'd1);
    chk("load_pc", ID_EX_pc, 32'h100);
    chk("load_imm", ID_EX_imm, 32'h1100);
    chk("load_rd2", ID_EX_rd2, 32'h3100);

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rs1", {27'd0, ID_EX_RS1}, 32'd0);
    chk("async_rst_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("async_rst_pcw", {31'd0, PC_Write}, 32'd0);
    #1 reset = 1'b0;
    step();
    chk("post_rst_rs1", {27'd0, ID_EX_RS1}, 32'd5);
    chk("post_rst_valid", {31'd0, ID_EX_valid}, 32'd1);

    // load-use: lw x3 then consumer of x3 in rs2
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h10, 9'h1A0);
    step();
    drive(1'b1, 5'd4, 5'd3, 5'd8, 32'h20, 9'h100);
    #1;
    chk("lu_pcw", {31'd0, PC_Write}, 32'd0);
    chk("lu_ifidw", {31'd0, IF_ID_Write}, 32'd0);
    step();
    chk("lu_bubble_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("lu_bubble_ctrl", {23'd0, ID_EX_ctrl}, 32'd0);
    chk("lu_bubble_rd", {27'd0, ID_EX_rd}, 32'd0);
    chk("lu_pcw_release", {31'd0, PC_Write}, 32'd1);
    step();
    chk("lu_dep_rd", {27'd0, ID_EX_rd}, 32'd8);
    chk("lu_dep_ctrl", {23'd0, ID_EX_ctrl}, 32'h100);
    chk("lu_stallcnt", Stall_Count, PERF ? 32'd1 : 32'd0);

    // load writing x0, consumer of x0: no stall
    drive(1'b1, 5'd1, 5'd2, 5'd0, 32'h30, 9'h1A0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 32'h38, 9'h100);
    #1;
    chk("x0_pcw", {31'd0, PC_Write}, 32'd1);
    step();
    chk("x0_load_pc", ID_EX_pc, 32'h38);
    chk("x0_load_valid", {31'd0, ID_EX_valid}, 32'd1);

    // Mem_Stall for 3 edges with Branch_Taken in the first
    drive(1'b1, 5'd11, 5'd12, 5'd13, 32'h40, 9'h100);
    Mem_Stall = 1'b1;
    Branch_Taken = 1'b1;
    #1;
    chk("ms_pcw", {31'd0, PC_Write}, 32'd0);
    step();
    chk("ms_hold1_pc", ID_EX_pc, 32'h38);
    Branch_Taken = 1'b0;
    step();
    chk("ms_hold2_pc", ID_EX_pc, 32'h38);
    step();
    chk("ms_hold3_pc", ID_EX_pc, 32'h38);
    chk("ms_hold3_rd", {27'd0, ID_EX_rd}, 32'd9);
    chk("ms_flushcnt_held", Flush_Count, 32'd0);
    Mem_Stall = 1'b0;
    #1;
    chk("ms_release_pcw", {31'd0, PC_Write}, 32'd1);
    step();
    chk("pend_bubble_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("pend_bubble_pc", ID_EX_pc, 32'd0);
    chk("pend_flushcnt", Flush_Count, PERF ? 32'd1 : 32'd0);
    step();
    chk("pend_done_pc", ID_EX_pc, 32'h40);

    // Branch_Taken together with a load-use hazard
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h50, 9'h1A0);
    step();
    drive(1'b1, 5'd3, 5'd4, 5'd14, 32'h58, 9'h100);
    Branch_Taken = 1'b1;
    #1;
    chk("bh_pcw", {31'd0, PC_Write}, 32'd1);
    step();
    Branch_Taken = 1'b0;
    chk("bh_bubble_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("bh_bubble_rd", {27'd0, ID_EX_rd}, 32'd0);
    chk("bh_stallcnt", Stall_Count, PERF ? 32'd1 : 32'd0);
    chk("bh_flushcnt", Flush_Count, PERF ? 32'd2 : 32'd0);

    // invalid decode slot with nonzero control loads as bubble
    step();
    drive(1'b0, 5'd21, 5'd22, 5'd23, 32'h60, 9'h1FF);
    step();
    chk("inv_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("inv_ctrl", {23'd0, ID_EX_ctrl}, 32'd0);

`ifdef ID_EX_PERF_EN
    // flush counter saturation from a preloaded maximum
    @(negedge clk);
    force dut.r_flush_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_flush_cnt;
    Branch_Taken = 1'b1;
    step();
    Branch_Taken = 1'b0;
    chk("sat_flushcnt", Flush_Count, 32'hFFFF_FFFF);
`else
    Branch_Taken = 1'b1;
    step();
    Branch_Taken = 1'b0;
    chk("noperf_flushcnt", Flush_Count, 32'd0);
    chk("noperf_stallcnt", Stall_Count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
